// File: rtl/alternate_ones_zeros_detector.sv
// Serial toggle checker: y_o is a registered flag that is high while the most
// recent LEN samples of x_i strictly alternate (...0101 or ...1010).
module alternate_ones_zeros_detector #(
  parameter  int LEN   = 3,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  output logic y_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic             y_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      prev_q  <= 1'b0;
      y_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      y_o     <= y_d;
    end
  end

  // The run saturates at LEN so a long alternating stream keeps y_o high
  // without the counter wrapping; a repeated bit starts a new run of one.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = x_i;
    y_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        run_d   = RUN_ONE;
        state_d = TRACK;
      end
      TRACK: begin
        if (x_i != prev_q) begin
          run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
        end else begin
          run_d = RUN_ONE;
        end
      end
      default: begin
        run_d   = RUN_ONE;
        state_d = TRACK;
      end
    endcase
    y_d = (run_d == RUN_MAX);
  end

endmodule

// File: tb/tb_alternate_ones_zeros_detector.sv
// Self-checking bench for alternate_ones_zeros_detector: vector tables per
// sequence, expected flags queued on drive and popped after each edge.
module tb_alternate_ones_zeros_detector;

  typedef struct {
    bit x;
    bit y;
  } vec_t;

  logic clk;
  logic reset;
  logic x3, x2, x8;
  logic y3, y2, y8;

  int n_vec;
  int n_err;
  bit exp_q[$];

  alternate_ones_zeros_detector #(.LEN(3)) dut3 (.clk(clk), .reset(reset), .x_i(x3), .y_o(y3));
  alternate_ones_zeros_detector #(.LEN(2)) dut2 (.clk(clk), .reset(reset), .x_i(x2), .y_o(y2));
  alternate_ones_zeros_detector #(.LEN(8)) dut8 (.clk(clk), .reset(reset), .x_i(x8), .y_o(y8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pick_y(input int sel);
    case (sel)
      2:       return y2;
      8:       return y8;
      default: return y3;
    endcase
  endfunction

  task automatic check_output(input int sel, input string name, input int idx);
    bit   exp;
    logic act;
    act = pick_y(sel);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL %s[%0d] LEN=%0d: scoreboard empty, got y_o=%b", name, idx, sel, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("[TB] FAIL %s[%0d] LEN=%0d: y_o=%b, expected %b", name, idx, sel, act, exp);
      end
    end
  endtask

  task automatic apply_stimulus(input int sel, input bit x, input bit exp,
                                input string name, input int idx);
    case (sel)
      2:       x2 = x;
      8:       x8 = x;
      default: x3 = x;
    endcase
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_output(sel, name, idx);
  endtask

  task automatic run_table(input int sel, input string name, input vec_t tbl[$]);
    foreach (tbl[i]) apply_stimulus(sel, tbl[i].x, tbl[i].y, name, i);
  endtask

  function automatic void add_vecs(inout vec_t tbl[$], input string xs, input string ys);
    vec_t v;
    for (int i = 0; i < xs.len(); i++) begin
      v.x = (xs[i] == "1");
      v.y = (ys[i] == "1");
      tbl.push_back(v);
    end
  endfunction

  // Hold reset for two edges with inputs toggling, then release between edges.
  task automatic do_reset(input string name);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x3 = i[0]; x2 = ~i[0]; x8 = i[0];
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      @(posedge clk);
      #1;
      check_output(3, name, i);
      check_output(2, name, i);
      check_output(8, name, i);
    end
    reset = 1'b1;
  endtask

  initial begin
    vec_t t_basic[$];
    vec_t t_sat[$];
    vec_t t_const[$];
    vec_t t_restart[$];
    vec_t t_len2[$];
    vec_t t_len8[$];
    vec_t v;

    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    x3 = 1'b0; x2 = 1'b0; x8 = 1'b0;

    add_vecs(t_basic,   "0010110011", "0001100000");
    add_vecs(t_sat,     "10101010",   "00111111");
    add_vecs(t_restart, "010010",     "001001");
    add_vecs(t_len2,    "1100",       "0010");
    add_vecs(t_len8,    "0101010101", "0000000111");
    for (int i = 0; i < 40; i++) begin
      v.x = (i < 20);
      v.y = 1'b0;
      t_const.push_back(v);
    end

    #2;
    do_reset("reset_hold");
    run_table(3, "basic", t_basic);

    do_reset("reset_hold");
    run_table(3, "saturate", t_sat);

    // Asynchronous reset while y_o is high must clear it before the next edge.
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(1'b0);
    check_output(3, "async_reset", 0);
    @(posedge clk);
    #1;
    exp_q.push_back(1'b0);
    check_output(3, "async_reset", 1);

    do_reset("reset_hold");
    run_table(3, "constant", t_const);

    do_reset("reset_hold");
    run_table(3, "restart", t_restart);

    do_reset("reset_hold");
    run_table(2, "len2", t_len2);

    do_reset("reset_hold");
    run_table(8, "len8", t_len8);

    // A history of alternation before a reset must not carry over afterwards.
    do_reset("reset_hold");
    apply_stimulus(3, 1'b1, 1'b0, "post_reset", 0);
    apply_stimulus(3, 1'b0, 1'b0, "post_reset", 1);
    apply_stimulus(3, 1'b1, 1'b1, "post_reset", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
